// File: rtl/axi4lite_slave_fifo.sv
// rtl/axi4lite_slave_fifo.sv - AXI4-Lite slave exposing a byte FIFO (DATA/STATUS/CTRL/COUNT).
// Optional AXIL_FIFO_SLVERR_EN: push-to-full and pop-from-empty answer SLVERR.
module axi4lite_slave_fifo #(
  parameter int C_S_AXI_ADDR_WIDTH = 2,
  parameter int C_S_AXI_DATA_WIDTH = 8,
  parameter int DEPTH              = 4
) (
  input  logic                          s_axi_aclk,
  input  logic                          s_axi_aresetn,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic                          s_axi_awvalid,
  output logic                          s_axi_awready,
  input  logic [C_S_AXI_DATA_WIDTH-1:0] s_axi_wdata,
  input  logic                          s_axi_wstrb,
  input  logic                          s_axi_wvalid,
  output logic                          s_axi_wready,
  output logic [1:0]                    s_axi_bresp,
  output logic                          s_axi_bvalid,
  input  logic                          s_axi_bready,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] s_axi_araddr,
  input  logic                          s_axi_arvalid,
  output logic                          s_axi_arready,
  output logic [C_S_AXI_DATA_WIDTH-1:0] s_axi_rdata,
  output logic [1:0]                    s_axi_rresp,
  output logic                          s_axi_rvalid,
  input  logic                          s_axi_rready
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  w_state_t w_state, w_next;
  r_state_t r_state, r_next;

  logic          active, act;
  logic [7:0]    mem [DEPTH];
  logic [PW-1:0] wptr, rptr;
  logic [CW-1:0] count;
  logic          ovf, und, full, empty;
  logic          wr_hs, rd_hs, push, pop, push_ok, pop_ok, ovf_evt, und_evt;
  logic          ctrl_wr, flush, clr;
  logic [7:0]    status, rd_mux;

  // Readies are held low in reset and for the first cycle after release.
  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) active <= 1'b0;
    else                active <= 1'b1;
  end
  assign act = active & s_axi_aresetn;

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      w_state <= W_IDLE;
      r_state <= R_IDLE;
    end else begin
      w_state <= w_next;
      r_state <= r_next;
    end
  end

  always_comb begin
    w_next = w_state;
    case (w_state)
      W_IDLE:  if (wr_hs) w_next = W_RESP;
      W_RESP:  if (s_axi_bready) w_next = W_IDLE;
      default: w_next = W_IDLE;
    endcase
  end

  always_comb begin
    r_next = r_state;
    case (r_state)
      R_IDLE:  if (rd_hs) r_next = R_DATA;
      R_DATA:  if (s_axi_rready) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  always_comb begin
    s_axi_awready = 1'b0;
    s_axi_wready  = 1'b0;
    s_axi_bvalid  = 1'b0;
    s_axi_arready = 1'b0;
    s_axi_rvalid  = 1'b0;
    if (w_state == W_IDLE) begin
      s_axi_awready = act & s_axi_awvalid & s_axi_wvalid;
      s_axi_wready  = act & s_axi_awvalid & s_axi_wvalid;
    end else begin
      s_axi_bvalid  = 1'b1;
    end
    if (r_state == R_IDLE) s_axi_arready = act;
    else                   s_axi_rvalid  = 1'b1;
  end

  assign wr_hs   = s_axi_awready;
  assign rd_hs   = s_axi_arready & s_axi_arvalid;
  assign push    = wr_hs & s_axi_wstrb & (s_axi_awaddr[1:0] == 2'd0);
  assign ctrl_wr = wr_hs & s_axi_wstrb & (s_axi_awaddr[1:0] == 2'd2);
  assign flush   = ctrl_wr & s_axi_wdata[0];
  assign clr     = ctrl_wr & s_axi_wdata[1];
  assign pop     = rd_hs & (s_axi_araddr[1:0] == 2'd0);

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  // Same-edge push and pop both see pre-edge state, so a pop frees room for a push to full.
  assign push_ok = push & (~full | pop);
  assign pop_ok  = pop & ~empty;
  assign ovf_evt = push & full & ~pop;
  assign und_evt = pop & empty;

  assign status = {4'b0000, und, ovf, full, empty};

  always_comb begin
    rd_mux = 8'h00;
    case (s_axi_araddr[1:0])
      2'd0:    rd_mux = empty ? 8'h00 : mem[rptr];
      2'd1:    rd_mux = status;
      2'd3:    rd_mux = 8'(count);
      default: rd_mux = 8'h00;
    endcase
  end

  always_ff @(posedge s_axi_aclk) begin
    if (push_ok) mem[wptr] <= s_axi_wdata[7:0];
  end

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
      ovf   <= 1'b0;
      und   <= 1'b0;
    end else begin
      if (flush) begin
        wptr  <= '0;
        rptr  <= '0;
        count <= '0;
      end else begin
        if (push_ok) wptr <= wptr + 1'b1;
        if (pop_ok)  rptr <= rptr + 1'b1;
        count <= count + CW'(push_ok) - CW'(pop_ok);
      end
      // A new event on the clearing edge keeps its flag set.
      ovf <= (ovf & ~clr) | ovf_evt;
      und <= (und & ~clr) | und_evt;
    end
  end

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      s_axi_bresp <= 2'b00;
      s_axi_rresp <= 2'b00;
      s_axi_rdata <= '0;
    end else begin
      if (wr_hs) begin
`ifdef AXIL_FIFO_SLVERR_EN
        s_axi_bresp <= ovf_evt ? 2'b10 : 2'b00;
`else
        s_axi_bresp <= 2'b00;
`endif
      end
      if (rd_hs) begin
        s_axi_rdata <= C_S_AXI_DATA_WIDTH'(rd_mux);
`ifdef AXIL_FIFO_SLVERR_EN
        s_axi_rresp <= und_evt ? 2'b10 : 2'b00;
`else
        s_axi_rresp <= 2'b00;
`endif
      end
    end
  end

endmodule

// File: tb/tb_axi4lite_slave_fifo.sv
// tb/tb_axi4lite_slave_fifo.sv - directed self-checking bench for axi4lite_slave_fifo.
module tb_axi4lite_slave_fifo;

  logic       clk;
  logic       resetn;
  logic [1:0] awaddr, araddr;
  logic       awvalid, awready, wvalid, wready, wstrb, bvalid, bready;
  logic       arvalid, arready, rvalid, rready;
  logic [7:0] wdata, rdata;
  logic [1:0] bresp, rresp;

  int pass_cnt = 0;
  int total    = 0;

  logic [7:0] rd;
  logic [1:0] rr, br;
  logic [1:0] err_resp;

  axi4lite_slave_fifo #(.C_S_AXI_ADDR_WIDTH(2), .C_S_AXI_DATA_WIDTH(8), .DEPTH(4)) dut (
    .s_axi_aclk(clk), .s_axi_aresetn(resetn),
    .s_axi_awaddr(awaddr), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_araddr(araddr), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rvalid(rvalid), .s_axi_rready(rready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total = total + 1;
    assert (obs === exp) pass_cnt = pass_cnt + 1;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic axi_write(input logic [1:0] a, input logic [7:0] d, input logic s,
                           output logic [1:0] resp);
    int n;
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1;
    #1;
    n = 0;
    while (!awready && n < 20) begin @(negedge clk); #1; n++; end
    chk("aw_wait", 8'(n < 20), 8'd1);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b1;
    @(negedge clk);
    n = 0;
    while (!bvalid && n < 20) begin @(negedge clk); n++; end
    chk("b_lat", 8'(n), 8'd0);
    resp = bresp;
    @(posedge clk); #1;
    bready = 1'b0;
    @(negedge clk);
  endtask

  task automatic axi_read(input logic [1:0] a, output logic [7:0] d, output logic [1:0] resp);
    int n;
    araddr = a; arvalid = 1'b1;
    #1;
    n = 0;
    while (!arready && n < 20) begin @(negedge clk); #1; n++; end
    chk("ar_wait", 8'(n < 20), 8'd1);
    @(posedge clk); #1;
    arvalid = 1'b0; rready = 1'b1;
    @(negedge clk);
    n = 0;
    while (!rvalid && n < 20) begin @(negedge clk); n++; end
    chk("r_lat", 8'(n), 8'd0);
    d = rdata; resp = rresp;
    @(posedge clk); #1;
    rready = 1'b0;
    @(negedge clk);
  endtask

  initial begin
`ifdef AXIL_FIFO_SLVERR_EN
    err_resp = 2'b10;
`else
    err_resp = 2'b00;
`endif
    resetn = 1'b0; awaddr = 0; araddr = 0; wdata = 0; wstrb = 1'b1;
    awvalid = 1'b1; wvalid = 1'b1; arvalid = 1'b1; bready = 1'b0; rready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_awready", 8'(awready), 8'd0);
    chk("rst_arready", 8'(arready), 8'd0);
    chk("rst_bvalid",  8'(bvalid),  8'd0);
    chk("rst_rvalid",  8'(rvalid),  8'd0);
    chk("rst_rdata",   rdata,       8'h00);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    resetn = 1'b1;
    @(negedge clk);
    chk("arready_rise", 8'(arready), 8'd1);

    axi_read(2'd1, rd, rr); chk("status_rst", rd, 8'h01);
    axi_read(2'd3, rd, rr); chk("count_rst",  rd, 8'h00);

    // Basic FIFO order
    axi_write(2'd0, 8'h11, 1'b1, br); chk("bresp_ok", 8'(br), 8'd0);
    axi_write(2'd0, 8'h22, 1'b1, br);
    axi_write(2'd0, 8'h33, 1'b1, br);
    axi_write(2'd0, 8'h44, 1'b1, br);
    axi_read(2'd1, rd, rr); chk("status_full", rd, 8'h02);
    axi_read(2'd3, rd, rr); chk("count_full",  rd, 8'h04);
    axi_read(2'd0, rd, rr); chk("pop0", rd, 8'h11);
    axi_read(2'd0, rd, rr); chk("pop1", rd, 8'h22);
    axi_read(2'd0, rd, rr); chk("pop2", rd, 8'h33);
    axi_read(2'd0, rd, rr); chk("pop3", rd, 8'h44); chk("rresp_ok", 8'(rr), 8'd0);
    axi_read(2'd1, rd, rr); chk("status_empty", rd, 8'h01);

    // Overflow, underflow, sticky clear
    axi_write(2'd0, 8'ha1, 1'b1, br);
    axi_write(2'd0, 8'ha2, 1'b1, br);
    axi_write(2'd0, 8'ha3, 1'b1, br);
    axi_write(2'd0, 8'ha4, 1'b1, br);
    axi_write(2'd0, 8'h55, 1'b1, br); chk("bresp_ovf", 8'(br), 8'(err_resp));
    axi_read(2'd1, rd, rr); chk("status_ovf", rd, 8'h06);
    axi_read(2'd0, rd, rr); chk("pop_a1", rd, 8'ha1);
    axi_read(2'd0, rd, rr); chk("pop_a2", rd, 8'ha2);
    axi_read(2'd0, rd, rr); chk("pop_a3", rd, 8'ha3);
    axi_read(2'd0, rd, rr); chk("pop_a4", rd, 8'ha4);
    axi_read(2'd0, rd, rr); chk("pop_und", rd, 8'h00); chk("rresp_und", 8'(rr), 8'(err_resp));
    axi_read(2'd1, rd, rr); chk("status_sticky", rd, 8'h0d);
    axi_write(2'd2, 8'h02, 1'b1, br); chk("bresp_ctrl", 8'(br), 8'd0);
    axi_read(2'd1, rd, rr); chk("status_clr", rd, 8'h01);
    axi_read(2'd2, rd, rr); chk("ctrl_reads0", rd, 8'h00);

    // Strobe-less write and RO-register write are no-ops
    axi_write(2'd0, 8'h99, 1'b0, br); chk("bresp_nostrb", 8'(br), 8'd0);
    axi_write(2'd3, 8'h07, 1'b1, br);
    axi_read(2'd3, rd, rr); chk("count_noop", rd, 8'h00);

    // Advance pointers by one so the next fill wraps
    axi_write(2'd0, 8'hb1, 1'b1, br);
    axi_read(2'd0, rd, rr); chk("pop_b1", rd, 8'hb1);
    axi_write(2'd0, 8'hc1, 1'b1, br);
    axi_write(2'd0, 8'hc2, 1'b1, br);
    axi_write(2'd0, 8'hc3, 1'b1, br);
    axi_write(2'd0, 8'hc4, 1'b1, br);

    // Push and pop on the same edge while full
    awaddr = 2'd0; wdata = 8'h66; wstrb = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 2'd0; arvalid = 1'b1;
    #1;
    chk("both_ready", {6'd0, awready, arready}, 8'h03);
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0; bready = 1'b1; rready = 1'b1;
    @(negedge clk);
    chk("same_bvalid", 8'(bvalid), 8'd1);
    chk("same_rvalid", 8'(rvalid), 8'd1);
    chk("same_rdata",  rdata, 8'hc1);
    chk("same_bresp",  8'(bresp), 8'd0);
    @(posedge clk); #1;
    bready = 1'b0; rready = 1'b0;
    @(negedge clk);
    axi_read(2'd3, rd, rr); chk("count_same", rd, 8'h04);
    axi_read(2'd1, rd, rr); chk("status_same", rd, 8'h02);
    axi_read(2'd0, rd, rr); chk("wrap_c2", rd, 8'hc2);
    axi_read(2'd0, rd, rr); chk("wrap_c3", rd, 8'hc3);
    axi_read(2'd0, rd, rr); chk("wrap_c4", rd, 8'hc4);
    axi_read(2'd0, rd, rr); chk("wrap_66", rd, 8'h66);
    axi_read(2'd1, rd, rr); chk("status_wrap", rd, 8'h01);

    // Flush
    axi_write(2'd0, 8'hd0, 1'b1, br);
    axi_write(2'd0, 8'hd1, 1'b1, br);
    axi_write(2'd2, 8'h01, 1'b1, br);
    axi_read(2'd3, rd, rr); chk("count_flush", rd, 8'h00);
    axi_write(2'd0, 8'he1, 1'b1, br);

    // Stalled responses, then reset in the middle of them
    awaddr = 2'd0; wdata = 8'h77; wstrb = 1'b1; awvalid = 1'b1; wvalid = 1'b1;
    araddr = 2'd3; arvalid = 1'b1;
    #1;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_bvalid",  8'(bvalid),  8'd1);
      chk("hold_rvalid",  8'(rvalid),  8'd1);
      chk("hold_rdata",   rdata,       8'h01);
      chk("hold_bresp",   8'(bresp),   8'd0);
      chk("hold_awready", 8'(awready), 8'd0);
      chk("hold_arready", 8'(arready), 8'd0);
    end
    resetn = 1'b0;
    @(negedge clk);
    chk("rst_mid_bvalid", 8'(bvalid), 8'd0);
    chk("rst_mid_rvalid", 8'(rvalid), 8'd0);
    chk("rst_mid_awrdy",  8'(awready), 8'd0);
    awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
    resetn = 1'b1;
    @(negedge clk);
    axi_read(2'd3, rd, rr); chk("count_after_rst",  rd, 8'h00);
    axi_read(2'd1, rd, rr); chk("status_after_rst", rd, 8'h01);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
